// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// PREFETCH_EN adds the PF1/PF2 states used to fill the next-pair prefetch buffer.
package instr_fetch_pkg;

  localparam int ADDR_W = 8;
  localparam logic [7:0] NOP_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    RSP  = 3'd3
`ifdef PREFETCH_EN
    ,
    PF1  = 3'd4,
    PF2  = 3'd5
`endif
  } fetch_state_t;

endpackage

// File: rtl/prog_rom_256x8.sv
// Single-port program memory: one write or one synchronous read per cycle.
// A read returns the value stored before any write on the same edge.
module prog_rom_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: returns mem[A] and mem[A+1] behind a valid/ready handshake.
// Define PREFETCH_EN to prefetch the following pair after each consumed response.
//
// state | meaning
// IDLE  | waiting for a request or a program-load write
// RD1   | reading byte A+1; byte A arrives from the RAM and lands in opcode1
// RD2   | byte A+1 arrives and lands in opcode2
// RSP   | response held until consumed; may accept the next request
// PF1   | (PREFETCH_EN) reading A+3; byte A+2 lands in the prefetch buffer
// PF2   | (PREFETCH_EN) byte A+3 lands in the prefetch buffer, buffer marked valid
module instr_fetch_unit #(
  parameter int ADDR_W = instr_fetch_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rom_address,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        opcode1,
  output logic [7:0]        opcode2,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data
);
  import instr_fetch_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic              idle_like;
  logic              accept;
  logic              ram_we;
`ifdef PREFETCH_EN
  logic [ADDR_W-1:0] addr_p2;
  logic [ADDR_W-1:0] pf_addr;
  logic [7:0]        pf_op1;
  logic [7:0]        pf_op2;
  logic              pf_valid;
  logic              pf_hit;

  assign addr_p2 = addr_q + ADDR_W'(2);
  assign pf_hit  = pf_valid & ~flush & (rom_address == pf_addr);
`endif

  assign addr_p1 = addr_q + ADDR_W'(1);

  // Prefetch states are background work: they behave like IDLE toward the loader and the CPU.
  always_comb begin
    idle_like = (state == IDLE);
`ifdef PREFETCH_EN
    if (state == PF1 || state == PF2) idle_like = 1'b1;
`endif
  end

  always_comb begin
    req_ready = 1'b0;
    if (!reset) begin
      if (idle_like)         req_ready = ~prog_we;
      else if (state == RSP) req_ready = rsp_ready | flush;
      else                   req_ready = flush;
    end
  end

  assign accept = req_valid & req_ready;
  assign ram_we = prog_we & idle_like;

  // The RAM address runs one step ahead of the state so each byte is ready when captured.
  always_comb begin
    ram_addr = addr_q;
    if (ram_we)            ram_addr = prog_addr;
    else if (accept)       ram_addr = rom_address;
    else if (state == RD1) ram_addr = addr_p1;
`ifdef PREFETCH_EN
    else if (state == RSP) ram_addr = addr_p2;
    else if (state == PF1) ram_addr = pf_addr + ADDR_W'(1);
`endif
  end

  prog_rom_256x8 #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rom (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (prog_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      opcode1   <= NOP_BYTE;
      opcode2   <= NOP_BYTE;
`ifdef PREFETCH_EN
      pf_addr   <= '0;
      pf_op1    <= NOP_BYTE;
      pf_op2    <= NOP_BYTE;
      pf_valid  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q    <= rom_address;
        state     <= RD1;
        rsp_valid <= 1'b0;
`ifdef PREFETCH_EN
        pf_valid  <= 1'b0;
        if (pf_hit) begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          opcode1   <= pf_op1;
          opcode2   <= pf_op2;
        end
`endif
      end else if (flush) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
`ifdef PREFETCH_EN
        pf_valid  <= 1'b0;
`endif
      end else begin
        case (state)
          RD1: begin
            opcode1 <= ram_q;
            state   <= RD2;
          end
          RD2: begin
            opcode2   <= ram_q;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
          RSP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
`ifdef PREFETCH_EN
              pf_addr   <= addr_p2;
              state     <= PF1;
`else
              state     <= IDLE;
`endif
            end
          end
`ifdef PREFETCH_EN
          PF1: begin
            pf_op1 <= ram_q;
            state  <= PF2;
          end
          PF2: begin
            pf_op2   <= ram_q;
            pf_valid <= 1'b1;
            state    <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
`ifdef PREFETCH_EN
        // A load write steals the RAM port, so any prefetch in progress is abandoned.
        if (prog_we) begin
          pf_valid <= 1'b0;
          if (idle_like) state <= IDLE;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a byte-array model of program memory.
// Build with PREFETCH_EN defined to also exercise the prefetch buffer.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] rom_address = 8'h00;
  logic       flush = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] mem_m [256];
  logic       pf_ok = 1'b0;
  logic [7:0] pf_a = 8'h00;
  int         con_cyc = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .rom_address (rom_address),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    #1;
    chk("write_blocks_req", req_ready, 1'b0);
    @(posedge clk); #1;
    prog_we = 1'b0;
    mem_m[a] = d;
    pf_ok = 1'b0;
  endtask

  // Handshake from an idle-like state; returns the latency the model expects.
  task automatic request(input logic [7:0] a, output int exp_l);
    req_valid = 1'b1;
    rom_address = a;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_l = 2;
`ifdef PREFETCH_EN
    // Buffer for A+2 is filled two cycles after the consuming edge, usable from the third.
    if (pf_ok && a == pf_a && (cyc - con_cyc) >= 3) exp_l = 0;
`endif
    pf_ok = 1'b0;
  endtask

  task automatic wait_rsp(input logic [7:0] a, input int exp_l, input int hold);
    int lat;
    logic [7:0] a1;
    a1 = a + 8'd1;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_l);
    chk("opcode1", opcode1, mem_m[a]);
    chk("opcode2", opcode2, mem_m[a1]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_op1", opcode1, mem_m[a]);
      chk("hold_op2", opcode2, mem_m[a1]);
      chk("hold_req_ready", req_ready, 1'b0);
    end
  endtask

  task automatic consume(input logic [7:0] a);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("consumed", rsp_valid, 1'b0);
    pf_ok = 1'b1;
    pf_a = a + 8'd2;
    con_cyc = cyc;
  endtask

  task automatic fetch(input logic [7:0] a, input int hold);
    int l;
    request(a, l);
    wait_rsp(a, l, hold);
    consume(a);
  endtask

  initial begin
    int l;
    logic [7:0] a;
    logic [7:0] b;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_opcode1", opcode1, 8'h00);
    chk("rst_opcode2", opcode2, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1;
      prog_addr = 8'(i);
      prog_data = 8'($urandom);
      @(posedge clk); #1;
      mem_m[i] = prog_data;
    end
    prog_we = 1'b0;
    @(posedge clk); #1;

    // basic fetch and address wrap
    write_byte(8'h10, 8'h15);
    write_byte(8'h11, 8'hA7);
    fetch(8'h10, 0);
    write_byte(8'hFF, 8'h81);
    write_byte(8'h00, 8'h23);
    fetch(8'hFF, 0);

    // consumer stall
    fetch(8'h10, 5);

    // flush in RD2 drops the response
    request(8'h20, l);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_no_rsp", rsp_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_still_no_rsp", rsp_valid, 1'b0);

    // flush with a new request restarts at the new address
    request(8'h20, l);
    flush = 1'b1;
    req_valid = 1'b1;
    rom_address = 8'h40;
    #1;
    chk("flush_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    wait_rsp(8'h40, 2, 0);
    consume(8'h40);

    // async reset during RD1
    request(8'h10, l);
    reset = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_opcode1", opcode1, 8'h00);
    chk("rst_mid_opcode2", opcode2, 8'h00);
    chk("rst_mid_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    pf_ok = 1'b0;
    @(posedge clk); #1;
    fetch(8'h10, 0);

    // back-to-back accept from RSP
    request(8'h30, l);
    wait_rsp(8'h30, l, 0);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    rom_address = 8'h31;
    #1;
    chk("b2b_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    wait_rsp(8'h31, 2, 0);
    consume(8'h31);

`ifdef PREFETCH_EN
    fetch(8'h00, 0);
    repeat (3) @(posedge clk);
    #1;
    fetch(8'h02, 0);
    repeat (3) @(posedge clk);
    #1;
    fetch(8'h08, 0);
    fetch(8'h00, 0);
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'h03, ~mem_m[3]);
    repeat (2) @(posedge clk);
    #1;
    fetch(8'h02, 0);
`endif

    // randomized mix checked against the memory model
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      case ($urandom_range(0, 3))
        0: write_byte(8'($urandom), 8'($urandom));
        3: begin
          a = 8'($urandom);
          b = 8'($urandom);
          request(a, l);
          wait_rsp(a, l, 0);
          rsp_ready = 1'b1;
          req_valid = 1'b1;
          rom_address = b;
          @(posedge clk); #1;
          rsp_ready = 1'b0;
          req_valid = 1'b0;
          wait_rsp(b, 2, 0);
          consume(b);
        end
        default: begin
          a = (pf_ok && $urandom_range(0, 1) == 1) ? pf_a : 8'($urandom);
          fetch(a, $urandom_range(0, 2));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
